branch_outcome_tracker: RTL and testbench

BRANCH_OUTCOME_TRACKER -- requirements
Module: branch_outcome_tracker

---
 rtl/branch_outcome_tracker_pkg.sv | 20 ++
 rtl/branch_entry_fifo.sv | 68 ++++++
 rtl/branch_outcome_tracker.sv | 115 +++++++++++
 tb/tb_branch_outcome_tracker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_outcome_tracker_pkg.sv
// Shared types and constants for the branch outcome tracker: the in-flight
// branch entry record and the instruction-length constants.
package branch_outcome_tracker_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int PC_W_DEFAULT  = 32;
    // Entries carry PCs at the widest supported width; narrower configs zero-extend.
    localparam int PC_MAX_W      = 64;

    localparam int INSN_LEN_C    = 2;
    localparam int INSN_LEN_N    = 4;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic                is_c;
        logic                pred;
        logic [PC_MAX_W-1:0] target;
    } branch_entry_t;

endpackage

// File: rtl/branch_entry_fifo.sv
// In-order storage for in-flight branches: tail push, head pop, and a
// single-cycle flush that empties the queue.
module branch_entry_fifo
    import branch_outcome_tracker_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  branch_entry_t entry_i,
    output branch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    branch_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entry storage is deliberately left out of reset; validity is
    // tracked by count, and an unreset array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_outcome_tracker.sv
// Tracks decoded conditional branches until they resolve in EX, emits
// predictor-update pulses and a flush/redirect on misprediction.
module branch_outcome_tracker
    import branch_outcome_tracker_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    parameter  int PC_W  = PC_W_DEFAULT,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            push_valid,
    input  logic [PC_W-1:0] push_pc,
    input  logic            push_is_c,
    input  logic            push_pred,
    input  logic [PC_W-1:0] push_target,
    input  logic            resolve_valid,
    input  logic            resolve_taken,
    output logic            taken,
    output logic            not_taken,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty,
    output logic            err
);

    branch_entry_t push_entry, head;
    logic          fifo_full, fifo_empty;
    logic          can_pop, head_mis, do_push;
    logic [PC_W-1:0] head_pc, head_tgt, fallthrough;

    logic            taken_q, taken_d;
    logic            not_taken_q, not_taken_d;
    logic            mispredict_q, mispredict_d;
    logic [PC_W-1:0] redirect_q, redirect_d;
    logic            err_q, err_d;

    always_comb begin
        push_entry        = '0;
        push_entry.pc     = PC_MAX_W'(push_pc);
        push_entry.is_c   = push_is_c;
        push_entry.pred   = push_pred;
        push_entry.target = PC_MAX_W'(push_target);
    end

    branch_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (do_push),
        .pop_i   (can_pop),
        .flush_i (head_mis),
        .entry_i (push_entry),
        .head_o  (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_pc     = head.pc[PC_W-1:0];
    assign head_tgt    = head.target[PC_W-1:0];
    assign fallthrough = head_pc + (head.is_c ? PC_W'(INSN_LEN_C) : PC_W'(INSN_LEN_N));

    generate
        if (PC_W < PC_MAX_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{head.pc[PC_MAX_W-1:PC_W], head.target[PC_MAX_W-1:PC_W]};
        end
    endgenerate

    // A mispredicting pop flushes the wrong path, which also kills any
    // same-cycle push; a correct pop frees a slot for a push even when full.
    always_comb begin
        can_pop  = !stall && resolve_valid && !fifo_empty;
        head_mis = can_pop && (head.pred != resolve_taken);
        do_push  = !stall && push_valid && !head_mis && (!fifo_full || can_pop);

        err_d = err_q;
        if (!stall && ((push_valid && fifo_full && !can_pop) || (resolve_valid && fifo_empty)))
            err_d = 1'b1;

        taken_d      = can_pop && resolve_taken;
        not_taken_d  = can_pop && !resolve_taken;
        mispredict_d = head_mis;
        redirect_d   = '0;
        if (head_mis) redirect_d = resolve_taken ? head_tgt : fallthrough;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q      <= 1'b0;
            not_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            taken_q      <= taken_d;
            not_taken_q  <= not_taken_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            err_q        <= err_d;
        end
    end

    assign taken       = taken_q;
    assign not_taken   = not_taken_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;
    assign err         = err_q;
    assign full        = fifo_full;
    assign empty       = fifo_empty;

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Directed bench for branch_outcome_tracker: a table of single-cycle vectors
// followed by hand sequences for stall, empty-resolve and async reset.
module tb_branch_outcome_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, push_valid, push_is_c, push_pred;
    logic [31:0] push_pc, push_target;
    logic        resolve_valid, resolve_taken;
    logic        taken, not_taken, mispredict, full, empty, err;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_outcome_tracker #(.DEPTH(4), .PC_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .push_valid    (push_valid),
        .push_pc       (push_pc),
        .push_is_c     (push_is_c),
        .push_pred     (push_pred),
        .push_target   (push_target),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .taken         (taken),
        .not_taken     (not_taken),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .err           (err)
    );

    typedef struct {
        logic        stall, pv;
        logic [31:0] pc;
        logic        is_c, pred;
        logic [31:0] tgt;
        logic        rv, rt;
        logic        e_taken, e_nt, e_mis;
        logic [31:0] e_redir;
        int          e_count;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic pv, logic [31:0] pc, logic is_c, logic pred,
                                logic [31:0] tgt, logic rv, logic rt, logic et, logic ent,
                                logic emis, logic [31:0] eredir, int ecount, logic eerr);
        vec_t v;
        v.stall = st; v.pv = pv; v.pc = pc; v.is_c = is_c; v.pred = pred; v.tgt = tgt;
        v.rv = rv; v.rt = rt; v.e_taken = et; v.e_nt = ent; v.e_mis = emis;
        v.e_redir = eredir; v.e_count = ecount; v.e_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic pv, input logic [31:0] pc, input logic is_c,
                         input logic pred, input logic [31:0] tgt, input logic rv, input logic rt);
        stall = st; push_valid = pv; push_pc = pc; push_is_c = is_c; push_pred = pred;
        push_target = tgt; resolve_valid = rv; resolve_taken = rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic et, input logic ent, input logic emis,
                              input logic [31:0] eredir, input int ecount, input logic eerr);
        check({tag, " taken"},       64'(taken),       64'(et));
        check({tag, " not_taken"},   64'(not_taken),   64'(ent));
        check({tag, " mispredict"},  64'(mispredict),  64'(emis));
        check({tag, " redirect_pc"}, 64'(redirect_pc), 64'(eredir));
        check({tag, " count"},       64'(count),       64'(ecount));
        check({tag, " empty"},       64'(empty),       64'(ecount == 0));
        check({tag, " full"},        64'(full),        64'(ecount == 4));
        check({tag, " err"},         64'(err),         64'(eerr));
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        #10;
        rst_n = 1'b1;

        //        st pv pc       c  p  tgt      rv rt  et nt ms redir    cnt err
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 0, 0, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 1, 32'h140, 0, 0, 0, 0, 0, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 1, 1, 1, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 1, 1, 32'h180, 0, 0, 0, 0, 0, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 1, 0, 0, 1, 1, 32'h202, 0, 0));
        vecs.push_back(mk(0, 1, 32'h300, 0, 0, 32'h3a0, 0, 0, 0, 0, 0, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 1, 1, 1, 0, 1, 32'h3a0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h400, 0, 0, 32'h480, 0, 0, 0, 0, 0, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 1, 0, 0, 1, 0, 32'h000, 0, 0));
        // Fill, then mispredict the head while a fifth push arrives.
        vecs.push_back(mk(0, 1, 32'h500, 0, 1, 32'h600, 0, 0, 0, 0, 0, 32'h000, 1, 0));
        vecs.push_back(mk(0, 1, 32'h504, 0, 1, 32'h600, 0, 0, 0, 0, 0, 32'h000, 2, 0));
        vecs.push_back(mk(0, 1, 32'h508, 0, 1, 32'h600, 0, 0, 0, 0, 0, 32'h000, 3, 0));
        vecs.push_back(mk(0, 1, 32'h50c, 0, 1, 32'h600, 0, 0, 0, 0, 0, 32'h000, 4, 0));
        vecs.push_back(mk(0, 1, 32'h510, 0, 1, 32'h600, 1, 0, 0, 1, 1, 32'h504, 0, 0));
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 0, 0, 0, 0, 32'h000, 0, 0));
        // Fill, push+correct pop while full, push while full, then drain in order.
        vecs.push_back(mk(0, 1, 32'h700, 1, 0, 32'h800, 0, 0, 0, 0, 0, 32'h000, 1, 0));
        vecs.push_back(mk(0, 1, 32'h702, 1, 0, 32'h800, 0, 0, 0, 0, 0, 32'h000, 2, 0));
        vecs.push_back(mk(0, 1, 32'h704, 1, 0, 32'h800, 0, 0, 0, 0, 0, 32'h000, 3, 0));
        vecs.push_back(mk(0, 1, 32'h706, 1, 0, 32'h800, 0, 0, 0, 0, 0, 32'h000, 4, 0));
        vecs.push_back(mk(0, 1, 32'h710, 0, 1, 32'h900, 1, 0, 0, 1, 0, 32'h000, 4, 0));
        vecs.push_back(mk(0, 1, 32'h720, 0, 1, 32'h900, 0, 0, 0, 0, 0, 32'h000, 4, 1));
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 1, 0, 0, 1, 0, 32'h000, 3, 1));
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 1, 0, 0, 1, 0, 32'h000, 2, 1));
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 1, 0, 0, 1, 0, 32'h000, 1, 1));
        vecs.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 1, 0, 0, 1, 1, 32'h714, 0, 1));
        vecs.push_back(mk(1, 1, 32'h730, 0, 1, 32'h900, 1, 1, 0, 0, 0, 32'h000, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].pv, vecs[i].pc, vecs[i].is_c, vecs[i].pred,
                  vecs[i].tgt, vecs[i].rv, vecs[i].rt);
            step();
            check_outs($sformatf("v%0d", i), vecs[i].e_taken, vecs[i].e_nt, vecs[i].e_mis,
                       vecs[i].e_redir, vecs[i].e_count, vecs[i].e_err);
        end

        // Stall blocks pops, pushes and err; resolve on empty sets err only.
        do_reset();
        check_outs("rst1", 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        step();
        check_outs("stall_empty", 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h100, 0, 1, 32'h140, 0, 0);
        step();
        check_outs("push_one", 0, 0, 0, 0, 1, 0);
        drive(1, 1, 32'h104, 0, 0, 32'h140, 1, 1);
        step();
        check_outs("stall_resolve", 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step();
        check_outs("unstall_pop", 1, 0, 0, 0, 0, 0);
        step();
        check_outs("resolve_empty", 0, 0, 0, 0, 0, 1);

        // Asynchronous reset with three entries queued.
        drive(0, 1, 32'h100, 0, 1, 32'h140, 0, 0);
        step();
        step();
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_outs("three_queued", 0, 0, 0, 0, 3, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst_entries", 0, 0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b1;

        // Asynchronous reset while mispredict is high.
        @(negedge clk);
        drive(0, 1, 32'h100, 0, 1, 32'h140, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_outs("mis_before_rst", 0, 1, 1, 32'h104, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst_mis", 0, 0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
